// File: rtl/brick_pkg.sv
// Shared types and helpers for the brick collision logic: coordinate widths,
// the hit-tracker state encoding and min/max helpers on box coordinates.
package brick_pkg;

    localparam int COORD_W = 11;
    // Box edges carry one extra bit so ball_x + BALL_SIZE - 1 never wraps.
    localparam int BOX_W   = COORD_W + 1;

    localparam logic [BOX_W-1:0] BOX_ONE = {{(BOX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    function automatic logic [BOX_W-1:0] box_min(
        input logic [BOX_W-1:0] a,
        input logic [BOX_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic [BOX_W-1:0] box_max(
        input logic [BOX_W-1:0] a,
        input logic [BOX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/brick_overlap.sv
// Combinational box-vs-rectangle test with inclusive edges; also reports the
// penetration depth on each axis (meaningful only while overlap is set).
module brick_overlap
    import brick_pkg::*;
#(
    parameter int RECT_LEFT  = 100,
    parameter int RECT_RIGHT = 140,
    parameter int RECT_UP    = 100,
    parameter int RECT_DOWN  = 110
) (
    input  logic [BOX_W-1:0] box_x0,
    input  logic [BOX_W-1:0] box_y0,
    input  logic [BOX_W-1:0] box_x1,
    input  logic [BOX_W-1:0] box_y1,
    output logic             overlap,
    output logic [BOX_W-1:0] ox,
    output logic [BOX_W-1:0] oy
);

    localparam logic [BOX_W-1:0] LEFT_C  = BOX_W'(RECT_LEFT);
    localparam logic [BOX_W-1:0] RIGHT_C = BOX_W'(RECT_RIGHT);
    localparam logic [BOX_W-1:0] UP_C    = BOX_W'(RECT_UP);
    localparam logic [BOX_W-1:0] DOWN_C  = BOX_W'(RECT_DOWN);

    logic overlap_x;
    logic overlap_y;

    always_comb begin
        overlap_x = (box_x1 >= LEFT_C) && (box_x0 <= RIGHT_C);
        overlap_y = (box_y1 >= UP_C)   && (box_y0 <= DOWN_C);
        overlap   = overlap_x && overlap_y;
    end

    always_comb begin
        ox = box_min(box_x1, RIGHT_C) - box_max(box_x0, LEFT_C) + BOX_ONE;
        oy = box_min(box_y1, DOWN_C)  - box_max(box_y0, UP_C)   + BOX_ONE;
    end

endmodule

// File: rtl/brick_hit_ctrl.sv
// Per-brick hit tracker: once per frame tests the ball against this brick,
// counts hits, marks the brick destroyed and emits one-cycle hit/bounce/score pulses.
module brick_hit_ctrl
    import brick_pkg::*;
#(
    parameter int BRICK_LEFT    = 100,
    parameter int BRICK_RIGHT   = 140,
    parameter int BRICK_UP      = 100,
    parameter int BRICK_DOWN    = 110,
    parameter int BALL_SIZE     = 8,
    parameter int HITS_TO_BREAK = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               level_restart,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    output logic               brick_vis,
    output logic               hit_pulse,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic               score_inc,
    output logic [2:0]         hit_count
);

    localparam logic [BOX_W-1:0] BALL_M1 = BOX_W'(BALL_SIZE - 1);
    localparam logic [2:0]       HITS_C  = 3'(HITS_TO_BREAK);

    state_t           state_reg;
    state_t           state_next;

    logic [BOX_W-1:0] box_x0_reg;
    logic [BOX_W-1:0] box_y0_reg;
    logic [BOX_W-1:0] box_x1_reg;
    logic [BOX_W-1:0] box_y1_reg;

    logic             overlap_comb;
    logic [BOX_W-1:0] ox_comb;
    logic [BOX_W-1:0] oy_comb;

    logic             overlap_reg;
    logic [BOX_W-1:0] ox_reg;
    logic [BOX_W-1:0] oy_reg;

    logic             brick_vis_reg;
    logic [2:0]       hit_count_reg;
    logic [2:0]       hit_count_inc;

    logic             hit_now;
    logic             destroy_now;
    logic             start_frame;

    assign start_frame = (state_reg == IDLE) && frame_tick && !brick_vis_reg && !level_restart;

    // Ball box is latched as the frame starts so the overlap logic sees a
    // registered, stable box for the whole CHECK cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            box_x0_reg <= '0;
            box_y0_reg <= '0;
            box_x1_reg <= '0;
            box_y1_reg <= '0;
        end else if (start_frame) begin
            box_x0_reg <= {1'b0, ball_x};
            box_y0_reg <= {1'b0, ball_y};
            box_x1_reg <= {1'b0, ball_x} + BALL_M1;
            box_y1_reg <= {1'b0, ball_y} + BALL_M1;
        end
    end

    brick_overlap #(
        .RECT_LEFT  (BRICK_LEFT),
        .RECT_RIGHT (BRICK_RIGHT),
        .RECT_UP    (BRICK_UP),
        .RECT_DOWN  (BRICK_DOWN)
    ) u_overlap (
        .box_x0  (box_x0_reg),
        .box_y0  (box_y0_reg),
        .box_x1  (box_x1_reg),
        .box_y1  (box_y1_reg),
        .overlap (overlap_comb),
        .ox      (ox_comb),
        .oy      (oy_comb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overlap_reg <= 1'b0;
            ox_reg      <= '0;
            oy_reg      <= '0;
        end else if (level_restart) begin
            overlap_reg <= 1'b0;
        end else if (state_reg == CHECK) begin
            overlap_reg <= overlap_comb;
            ox_reg      <= ox_comb;
            oy_reg      <= oy_comb;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic; restart wins over everything
    always_comb begin
        state_next = state_reg;
        if (level_restart) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = start_frame ? CHECK : IDLE;
                CHECK:   state_next = RESOLVE;
                RESOLVE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs; pulses depend on registered state only, gated by restart
    always_comb begin
        hit_count_inc = hit_count_reg + 3'd1;
        hit_now       = (state_reg == RESOLVE) && overlap_reg && !brick_vis_reg && !level_restart;
        destroy_now   = hit_now && (hit_count_inc == HITS_C);
        hit_pulse     = hit_now;
        bounce_x      = hit_now && (ox_reg < oy_reg);
        bounce_y      = hit_now && !(ox_reg < oy_reg);
        score_inc     = destroy_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brick_vis_reg <= 1'b0;
            hit_count_reg <= 3'd0;
        end else if (level_restart) begin
            brick_vis_reg <= 1'b0;
            hit_count_reg <= 3'd0;
        end else if (hit_now) begin
            hit_count_reg <= hit_count_inc;
            if (destroy_now) begin
                brick_vis_reg <= 1'b1;
            end
        end
    end

    assign brick_vis = brick_vis_reg;
    assign hit_count = hit_count_reg;

endmodule
